// File: rtl/vl_pipe_arb_if.sv
// vl_pipe_arb bundle: request, return, inflight and drain signals.
// The flush wire exists only when VL_PIPE_ARB_FLUSH_EN is defined.
interface vl_pipe_arb_if #(
  parameter int NREQ       = 4,
  parameter int PIPE_DEPTH = 2,
  parameter int PIPE_DW    = 8
);
  localparam int CW = $clog2(PIPE_DEPTH + 1);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*PIPE_DW-1:0] req_data;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         rsp_valid;
  logic [PIPE_DW-1:0]      rsp_data;
  logic [CW-1:0]           inflight;
  logic                    drain_req;
  logic                    drained;
`ifdef VL_PIPE_ARB_FLUSH_EN
  logic                    flush;
`endif

  modport master (
`ifdef VL_PIPE_ARB_FLUSH_EN
    output flush,
`endif
    output req_valid,
    output req_data,
    output drain_req,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  inflight,
    input  drained
  );

  modport slave (
`ifdef VL_PIPE_ARB_FLUSH_EN
    input  flush,
`endif
    input  req_valid,
    input  req_data,
    input  drain_req,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output inflight,
    output drained
  );
endinterface

// File: rtl/vl_pipe_arb.sv
// Round-robin arbiter sharing one fixed-latency vl_pipe among NREQ requesters.
// Optional flush path enabled by defining VL_PIPE_ARB_FLUSH_EN.
module vl_pipe #(
  parameter int PIPE_DEPTH = 2,
  parameter int PIPE_DW    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PIPE_DW-1:0] din,
  output logic [PIPE_DW-1:0] dout
);
  logic [PIPE_DW-1:0] stage [PIPE_DEPTH];

  // plain delay line, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < PIPE_DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[PIPE_DEPTH-1];
endmodule

module vl_pipe_arb #(
  parameter int NREQ       = 4,
  parameter int PIPE_DEPTH = 2,
  parameter int PIPE_DW    = 8
) (
  input logic          clk,
  input logic          reset,
  vl_pipe_arb_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(PIPE_DEPTH + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t             state;
  state_t             state_nx;
  logic [IW-1:0]      last;
  logic [IW-1:0]      cand;
  logic [IW-1:0]      hit_id;
  logic               hit;
  logic               issue_ok;
  logic               gnt;
  logic               retire;
  logic               flush_i;
  logic [NREQ-1:0]    ready;
  logic [NREQ-1:0]    rsp;
  logic [PIPE_DW-1:0] pipe_din;
  logic [PIPE_DW-1:0] pipe_dout;
  logic [PIPE_DEPTH-1:0] tag_v;
  logic [IW-1:0]      tag_id [PIPE_DEPTH];
  logic [CW-1:0]      inflight;

`ifdef VL_PIPE_ARB_FLUSH_EN
  assign flush_i = bus.flush;
`else
  assign flush_i = 1'b0;
`endif

  assign issue_ok = (state == RUN) & ~bus.drain_req & ~reset & ~flush_i;

  // first valid requester after the last grant, wrapping
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!hit && bus.req_valid[cand]) begin
        hit    = 1'b1;
        hit_id = cand;
      end
    end
  end

  assign gnt = hit & issue_ok;

  // one-hot ready for the selected requester
  always_comb begin
    ready = '0;
    if (gnt) ready[hit_id] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign pipe_din = gnt ? bus.req_data[hit_id*PIPE_DW +: PIPE_DW] : '0;

  // round-robin pointer follows each grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last <= IW'(NREQ - 1);
    else if (gnt) last <= hit_id;
  end

  vl_pipe #(
    .PIPE_DEPTH(PIPE_DEPTH),
    .PIPE_DW   (PIPE_DW)
  ) u_pipe (
    .clk    (clk),
    .reset_n(~reset),
    .din    (pipe_din),
    .dout   (pipe_dout)
  );

  // valid/id tags move in lockstep with the pipe data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) tag_id[i] <= '0;
    end else begin
      if (flush_i) begin
        tag_v <= '0;
      end else begin
        tag_v[0] <= gnt;
        for (int i = 1; i < PIPE_DEPTH; i++) tag_v[i] <= tag_v[i-1];
      end
      tag_id[0] <= hit_id;
      for (int i = 1; i < PIPE_DEPTH; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  assign retire = tag_v[PIPE_DEPTH-1];

  // route the return strobe back to the originator
  always_comb begin
    rsp = '0;
    if (retire) rsp[tag_id[PIPE_DEPTH-1]] = 1'b1;
  end

  assign bus.rsp_valid = rsp;
  assign bus.rsp_data  = pipe_dout;

  // words in the pipe; flush wins over a retire
  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight <= '0;
    else if (flush_i) inflight <= '0;
    else if (gnt && !retire) inflight <= inflight + CW'(1);
    else if (!gnt && retire) inflight <= inflight - CW'(1);
  end

  assign bus.inflight = inflight;

  // drain FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else state <= state_nx;
  end

  // drain FSM transitions
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (bus.drain_req) state_nx = DRAIN;
      DRAIN:   if (inflight == '0) state_nx = HALT;
      HALT:    if (!bus.drain_req) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  assign bus.drained = (state == HALT);
endmodule

// File: tb/tb_vl_pipe_arb.sv
// Randomized bench for vl_pipe_arb at depth 2 and depth 1.
// Reference model schedules returns on a cycle calendar.
module tb_vl_pipe_arb;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    rv;
  logic [NREQ*DW-1:0] rd;
  logic               drain;
  logic               fl;

  vl_pipe_arb_if #(.NREQ(NREQ), .PIPE_DEPTH(2), .PIPE_DW(DW)) bus0 ();
  vl_pipe_arb_if #(.NREQ(NREQ), .PIPE_DEPTH(1), .PIPE_DW(DW)) bus1 ();

  assign bus0.req_valid = rv;
  assign bus0.req_data  = rd;
  assign bus0.drain_req = drain;
  assign bus1.req_valid = rv;
  assign bus1.req_data  = rd;
  assign bus1.drain_req = drain;
`ifdef VL_PIPE_ARB_FLUSH_EN
  assign bus0.flush = fl;
  assign bus1.flush = fl;
`endif

  vl_pipe_arb #(.NREQ(NREQ), .PIPE_DEPTH(2), .PIPE_DW(DW)) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0.slave)
  );

  vl_pipe_arb #(.NREQ(NREQ), .PIPE_DEPTH(1), .PIPE_DW(DW)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int          dep [2] = '{2, 1};
  int          last_m [2];
  int          st_m [2];
  bit          cv [2][8];
  int          cid [2][8];
  logic [DW-1:0] cd [2][8];
  int          cyc;

  logic [NREQ-1:0] o_rdy [2];
  logic [NREQ-1:0] o_rsp [2];
  logic [DW-1:0]   o_dat [2];
  int              o_inf [2];
  logic            o_drn [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_m[k] = NREQ - 1;
      st_m[k] = 0;
      for (int s = 0; s < 8; s++) cv[k][s] = 1'b0;
    end
  endtask

  task automatic sample();
    o_rdy[0] = bus0.req_ready;
    o_rsp[0] = bus0.rsp_valid;
    o_dat[0] = bus0.rsp_data;
    o_inf[0] = int'(bus0.inflight);
    o_drn[0] = bus0.drained;
    o_rdy[1] = bus1.req_ready;
    o_rsp[1] = bus1.rsp_valid;
    o_dat[1] = bus1.rsp_data;
    o_inf[1] = int'(bus1.inflight);
    o_drn[1] = bus1.drained;
  endtask

  task automatic chk_reset_vals();
    sample();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_rdy%0d", k), 32'(o_rdy[k]), 32'd0);
      chk($sformatf("rst_rsp%0d", k), 32'(o_rsp[k]), 32'd0);
      chk($sformatf("rst_dat%0d", k), 32'(o_dat[k]), 32'd0);
      chk($sformatf("rst_inf%0d", k), 32'(o_inf[k]), 32'd0);
      chk($sformatf("rst_drn%0d", k), 32'(o_drn[k]), 32'd0);
    end
  endtask

  task automatic check_cycle();
    sample();
    for (int k = 0; k < 2; k++) begin
      int g;
      int inf;
      int s0;
      logic [31:0] exp_rdy;
      logic [31:0] exp_rsp;
      g = -1;
      inf = 0;
      s0 = cyc % 8;
      for (int s = 0; s < 8; s++) if (cv[k][s]) inf++;
      if (st_m[k] == 0 && !drain && !fl) begin
        for (int j = 1; j <= NREQ; j++) begin
          int c;
          c = (last_m[k] + j) % NREQ;
          if (g < 0 && rv[c]) g = c;
        end
      end
      exp_rdy = (g >= 0) ? 32'(1 << g) : 32'd0;
      exp_rsp = cv[k][s0] ? 32'(1 << cid[k][s0]) : 32'd0;
      chk($sformatf("rdy%0d@%0d", k, cyc), 32'(o_rdy[k]), exp_rdy);
      chk($sformatf("rsp%0d@%0d", k, cyc), 32'(o_rsp[k]), exp_rsp);
      if (cv[k][s0])
        chk($sformatf("dat%0d@%0d", k, cyc), 32'(o_dat[k]), 32'(cd[k][s0]));
      chk($sformatf("inf%0d@%0d", k, cyc), 32'(o_inf[k]), 32'(inf));
      chk($sformatf("drn%0d@%0d", k, cyc), 32'(o_drn[k]),
          32'(st_m[k] == 2));
      cv[k][s0] = 1'b0;
      case (st_m[k])
        0: if (drain) st_m[k] = 1;
        1: if (inf == 0) st_m[k] = 2;
        default: if (!drain) st_m[k] = 0;
      endcase
      if (fl) for (int s = 0; s < 8; s++) cv[k][s] = 1'b0;
      if (g >= 0) begin
        last_m[k] = g;
        cv[k][(cyc + dep[k]) % 8] = 1'b1;
        cid[k][(cyc + dep[k]) % 8] = g;
        cd[k][(cyc + dep[k]) % 8] = rd[g*DW +: DW];
      end
    end
    cyc++;
  endtask

  initial begin
    rv = '0;
    rd = '0;
    drain = 1'b0;
    fl = 1'b0;
    cyc = 0;
    model_reset();
    @(negedge clk);
    rv = '1;
    #1;
    chk_reset_vals();
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i < 16) begin
        rv = '1;
      end else if (i % 100 < 50) begin
        rv = NREQ'($urandom);
      end else begin
        rv = NREQ'($urandom & $urandom);
      end
      rd = $urandom;
      if (i >= 16 && ($urandom % 10) == 0) drain = ~drain;
`ifdef VL_PIPE_ARB_FLUSH_EN
      fl = (i >= 16) && (($urandom % 15) == 0);
`endif
      #1;
      check_cycle();
      if (i == 200 || i == 450) begin
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
